// File: rtl/fft_strm_feeder_pkg.sv
// -----------------------------------------------------------------------------
// fft_strm_feeder_pkg
// Shared definitions for the FFT stream feeder:
//   - state_e    : feeder FSM encodings (IDLE / ARM / STREAM)
//   - ceil_log2  : width helper used to derive pointer, counter and level widths
// -----------------------------------------------------------------------------
package fft_strm_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // Smallest r with 2**r >= n.
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_strm_feeder_if.sv
// -----------------------------------------------------------------------------
// fft_strm_feeder_if
// Bundles the two handshakes of the feeder:
//   upstream : S_VALID, S_READY, S_RE, S_IM        (sample source -> feeder)
//   FFT side : RFS, START, INVERSE, DATAI_RE/IM    (feeder <-> FFT core)
// Modports:
//   slave  : the feeder (consumes samples, drives the FFT core inputs)
//   master : the environment (sample source + FFT core)
// -----------------------------------------------------------------------------
interface fft_strm_feeder_if #(
    parameter int DATA_BITS = 16
);
    logic                        S_VALID;
    logic                        S_READY;
    logic signed [DATA_BITS-1:0] S_RE;
    logic signed [DATA_BITS-1:0] S_IM;
    logic                        RFS;
    logic                        START;
    logic                        INVERSE;
    logic signed [DATA_BITS-1:0] DATAI_RE;
    logic signed [DATA_BITS-1:0] DATAI_IM;

    modport slave (
        input  S_VALID, S_RE, S_IM, RFS,
        output S_READY, START, INVERSE, DATAI_RE, DATAI_IM
    );

    modport master (
        output S_VALID, S_RE, S_IM, RFS,
        input  S_READY, START, INVERSE, DATAI_RE, DATAI_IM
    );
endinterface

// File: rtl/fft_feeder_fifo_ram.sv
// -----------------------------------------------------------------------------
// fft_feeder_fifo_ram
// Simple dual-port RAM backing the feeder FIFO. One write port, one read port,
// both on clk and qualified by clken_i. The read is registered: rdata_o shows
// mem[raddr_i] the cycle after re_i, and holds otherwise.
// Ports:
//   clk, rst          : clock, async active-high reset (read register only)
//   clken_i           : global clock enable
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read request
//   rdata_o           : registered read data
// -----------------------------------------------------------------------------
module fft_feeder_fifo_ram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 512,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (clken_i && we_i) mem_q[waddr_i] <= wdata_i;
    end

    // The read register is what the FFT core sees, so it must come up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (clken_i && re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_strm_feeder.sv
// -----------------------------------------------------------------------------
// fft_strm_feeder
// Frame source for a streaming FFT core. Buffers upstream complex samples in a
// FIFO_FRAMES-frame FIFO and, once a whole frame is buffered and the core has
// held RFS for two consecutive cycles, issues a one-cycle START and streams
// FFT_SIZE samples back-to-back, one per CLKEN cycle.
// Ports:
//   CLK, RST  : clock, async active-high reset
//   CLKEN     : global clock enable, all state holds when low
//   FLUSH     : synchronous abort, clears FIFO and FSM
//   INV_CFG   : direction latched onto INVERSE at each START
//   BUSY      : high while a frame is streaming
//   LEVEL     : FIFO occupancy in samples
//   bus       : upstream valid/ready stream and FFT-core handshake (slave)
// -----------------------------------------------------------------------------
module fft_strm_feeder
    import fft_strm_feeder_pkg::*;
#(
    parameter  int DATA_BITS   = 16,
    parameter  int FFT_SIZE    = 256,
    parameter  int FIFO_FRAMES = 2,
    localparam int LOG2PTS     = ceil_log2(FFT_SIZE),
    localparam int DEPTH       = FIFO_FRAMES * FFT_SIZE,
    localparam int ADDR_BITS   = ceil_log2(DEPTH),
    localparam int LVL_BITS    = ADDR_BITS + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLKEN,
    input  logic                FLUSH,
    input  logic                INV_CFG,
    output logic                BUSY,
    output logic [LVL_BITS-1:0] LEVEL,
    fft_strm_feeder_if.slave    bus
);
    state_e                 state_q, state_d;
    logic [LVL_BITS-1:0]    lvl_q, lvl_d, lvl_avail;
    logic [ADDR_BITS-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LOG2PTS-1:0]     cnt_q, cnt_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   inv_q, inv_d;
    logic                   rfs_q;
    logic                   s_ready, push, pop, launch_ok, last_smp, frame_rdy, launch;
    logic [2*DATA_BITS-1:0] rd_data;

    // Ready depends only on registered LEVEL, so a push can never land at full.
    assign s_ready   = ~RST & ~FLUSH & (lvl_q < LVL_BITS'(DEPTH));
    assign push      = bus.S_VALID & s_ready;
    // The core accepts START only once RFS has been high for a full cycle.
    assign launch_ok = bus.RFS & rfs_q;
    assign last_smp  = (cnt_q == LOG2PTS'(FFT_SIZE - 1));
    assign lvl_avail = lvl_q + LVL_BITS'(push);
    assign frame_rdy = (lvl_avail >= LVL_BITS'(FFT_SIZE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        inv_d   = inv_q;
        pop     = 1'b0;
        launch  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (lvl_q >= LVL_BITS'(FFT_SIZE)) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (launch_ok) launch = 1'b1;
            end
            ST_STREAM: begin
                if (!last_smp) begin
                    cnt_d = cnt_q + 1'b1;
                    pop   = 1'b1;
                end else if (frame_rdy && launch_ok) begin
                    // Back-to-back frame: next START directly follows the last sample.
                    launch = 1'b1;
                end else begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = frame_rdy ? ST_ARM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Launch reads the head sample so it sits in the RAM output register
        // during the START cycle; later pops read one sample ahead of DATAI.
        if (launch) begin
            state_d = ST_STREAM;
            cnt_d   = '0;
            start_d = 1'b1;
            busy_d  = 1'b1;
            inv_d   = INV_CFG;
            pop     = 1'b1;
        end

        lvl_d  = lvl_q + LVL_BITS'(push) - LVL_BITS'(pop);
        wptr_d = wptr_q + ADDR_BITS'(push);
        rptr_d = rptr_q + ADDR_BITS'(pop);

        if (FLUSH) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            start_d = 1'b0;
            busy_d  = 1'b0;
            pop     = 1'b0;
            lvl_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            inv_q   <= 1'b0;
            rfs_q   <= 1'b0;
        end else if (CLKEN) begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            inv_q   <= inv_d;
            rfs_q   <= bus.RFS;
        end
    end

    fft_feeder_fifo_ram #(
        .WIDTH     (2 * DATA_BITS),
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (CLK),
        .rst     (RST),
        .clken_i (CLKEN),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i ({bus.S_RE, bus.S_IM}),
        .re_i    (pop),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    assign bus.S_READY  = s_ready;
    assign bus.START    = start_q;
    assign bus.INVERSE  = inv_q;
    assign bus.DATAI_RE = rd_data[2*DATA_BITS-1:DATA_BITS];
    assign bus.DATAI_IM = rd_data[DATA_BITS-1:0];
    assign BUSY         = busy_q;
    assign LEVEL        = lvl_q;
endmodule
